// File: rtl/game_tick_if.sv
// Bundle of the tick scheduler's game-side signals: run/frame controls, divisor
// configuration, and the per-channel dispatch/ack handshake.
interface game_tick_if #(
   parameter int NUM_CH    = 4,
   parameter int DIV_WIDTH = 6,
   parameter int CH_W      = 2
);
   logic                 enb;
   logic                 frame_tick;
   logic                 cfg_we;
   logic [CH_W-1:0]      cfg_ch;
   logic [DIV_WIDTH-1:0] cfg_div;
   logic [NUM_CH-1:0]    ch_ack;
   logic [NUM_CH-1:0]    ch_tick;
   logic                 busy;
   logic [NUM_CH-1:0]    overrun;
   logic                 timeout;

   // Handshake: ch_tick[c] is a one-cycle dispatch pulse; the consumer completes it by
   // raising ch_ack[c] on any cycle from the pulse onward, and busy stays high until then.
   modport master (
      output enb, frame_tick, cfg_we, cfg_ch, cfg_div, ch_ack,
      input  ch_tick, busy, overrun, timeout
   );

   modport slave (
      input  enb, frame_tick, cfg_we, cfg_ch, cfg_div, ch_ack,
      output ch_tick, busy, overrun, timeout
   );
endinterface

// File: rtl/game_tick_scheduler.sv
// Divides the frame tick per channel and hands out one tick pulse at a time, round robin.
// Optional macro ACK_TIMEOUT_EN adds a WAIT_ACK watchdog that abandons a silent consumer.
module game_tick_scheduler #(
   parameter int NUM_CH      = 4,
   parameter int DIV_WIDTH   = 6,
   parameter int CH_W        = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst,
   game_tick_if.slave        io_bus,
   output logic              o_dbg_state,
   output logic [NUM_CH-1:0] o_dbg_pending
);

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_ACK = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [DIV_WIDTH-1:0] r_div [NUM_CH];
   logic [DIV_WIDTH-1:0] r_cnt [NUM_CH];
   logic [NUM_CH-1:0]    r_pending;
   logic [NUM_CH-1:0]    r_overrun;
   logic [NUM_CH-1:0]    r_ch_tick;
   logic [CH_W-1:0]      r_rr;
   logic [CH_W-1:0]      r_sel;

   logic                 w_tick_en;
   logic [NUM_CH-1:0]    w_cfg_hit;
   logic [NUM_CH-1:0]    w_expire;
   logic [NUM_CH-1:0]    w_clear;
   logic                 w_found;
   logic [CH_W-1:0]      w_pick;
   logic                 w_launch;
   logic                 w_done;
   logic                 w_ack_hit;
   logic                 w_to_expire;
   logic                 w_timeout;

   function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] a, input int k);
      int s;
      s = int'(a) + k;
      if (s >= NUM_CH) s = s - NUM_CH;
      return CH_W'(s);
   endfunction

   function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
      logic [NUM_CH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign w_tick_en = io_bus.enb && io_bus.frame_tick;

   // A config write to a channel masks that channel's expiry in the same cycle.
   always_comb begin
      w_cfg_hit = '0;
      w_expire  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_cfg_hit[i] = io_bus.cfg_we && (io_bus.cfg_ch == CH_W'(i));
         w_expire[i]  = w_tick_en && !w_cfg_hit[i] &&
                        (r_div[i] != '0) && (r_cnt[i] == '0);
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!w_found && r_pending[wrap_add(r_rr, k)]) begin
            w_found = 1'b1;
            w_pick  = wrap_add(r_rr, k);
         end
      end
   end

   assign w_ack_hit = (r_state == ST_WAIT_ACK) && io_bus.ch_ack[r_sel];
   assign w_clear   = w_done ? onehot(r_sel) : '0;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_launch    = 1'b1;
               w_state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (w_ack_hit || w_to_expire) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Expiry while the same channel is being cleared keeps it pending without an overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_div[i] <= '0;
            r_cnt[i] <= '0;
         end
         r_pending <= '0;
         r_overrun <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_cfg_hit[i]) begin
               r_div[i]     <= io_bus.cfg_div;
               r_cnt[i]     <= (io_bus.cfg_div == '0) ? '0 : io_bus.cfg_div - DIV_WIDTH'(1);
               r_overrun[i] <= 1'b0;
            end else if (w_tick_en && (r_div[i] != '0)) begin
               r_cnt[i] <= (r_cnt[i] == '0) ? r_div[i] - DIV_WIDTH'(1)
                                            : r_cnt[i] - DIV_WIDTH'(1);
            end
            if (w_expire[i]) begin
               if (r_pending[i] && !w_clear[i]) r_overrun[i] <= 1'b1;
               r_pending[i] <= 1'b1;
            end else if (w_clear[i]) begin
               r_pending[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr      <= '0;
         r_sel     <= '0;
         r_ch_tick <= '0;
      end else begin
         r_ch_tick <= w_launch ? onehot(w_pick) : '0;
         if (w_launch) r_sel <= w_pick;
         if (w_done)   r_rr  <= wrap_add(r_sel, 1);
      end
   end

`ifdef ACK_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TO_W-1:0] r_to_cnt;
   logic            r_timeout;

   // Counter is zero on the first WAIT_ACK cycle; an ack in the final cycle still wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_launch)                     r_to_cnt <= '0;
         else if (r_state == ST_WAIT_ACK)  r_to_cnt <= r_to_cnt + TO_W'(1);
         if (w_to_expire && !w_ack_hit)    r_timeout <= 1'b1;
      end
   end

   assign w_to_expire = (r_state == ST_WAIT_ACK) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign w_timeout   = r_timeout;
`else
   assign w_to_expire = 1'b0;
   assign w_timeout   = 1'b0;
`endif

   assign io_bus.ch_tick = r_ch_tick;
   assign io_bus.busy    = (r_state == ST_WAIT_ACK);
   assign io_bus.overrun = r_overrun;
   assign io_bus.timeout = w_timeout;

   assign o_dbg_state    = (r_state == ST_WAIT_ACK);
   assign o_dbg_pending  = r_pending;

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Shares the once-per-frame game tick among NUM_CH game-logic consumers: alien march, player shots, alien bombs, UFO. Each channel has a programmable frame divisor. When its divisor expires, the channel gets a pending request. A round-robin dispatcher issues one tick pulse at a time and waits for the consumer's ack. The block sits between the frame-synchronous global tick counter and the sprite/motion FSMs.

Parameters:
NUM_CH, 4, number of consumer channels (2..8)
DIV_WIDTH, 6, width of per-channel frame divisor
CH_W, 2, width of channel index (must hold NUM_CH-1)
TIMEOUT_CYC, 1024, ack timeout in clk cycles (used only with ACK_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enb  in  1  game run enable; low freezes divisor counters
frame_tick  in  1  one-cycle pulse once per frame from the global counter
cfg_we  in  1  divisor write strobe
cfg_ch  in  CH_W  channel index for the write
cfg_div  in  DIV_WIDTH  divisor in frames; 0 = channel disabled
ch_ack  in  NUM_CH  per-channel consumer ack
ch_tick  out  NUM_CH  one-hot one-cycle dispatch pulse
busy  out  1  high while in WAIT_ACK
overrun  out  NUM_CH  sticky: a period expired while that channel was still pending
timeout  out  1  sticky ack-timeout flag (constant 0 without ACK_TIMEOUT_EN)

Behaviour:
- Clock is clk. Reset is synchronous, active-high on rst. Everything is sampled on posedge clk.
- Reset values:
  - div[], cnt[], pending[] = 0.
  - rr pointer = 0; state = IDLE.
  - ch_tick = 0, busy = 0, overrun = 0, timeout = 0.
  - Reset mid-handshake abandons the handshake and drops ch_tick in the next cycle.
- Config write (cfg_we=1):
  - div[cfg_ch] <= cfg_div.
  - cnt[cfg_ch] <= cfg_div-1, or 0 if cfg_div=0.
  - overrun[cfg_ch] <= 0. pending is not touched.
  - cfg_ch >= NUM_CH is ignored.
- Divisor counters, per channel i with div[i] != 0, on each cycle with enb && frame_tick:
  - If cnt[i]==0: set pending[i] and reload cnt[i] <= div[i]-1.
  - Otherwise: cnt[i] <= cnt[i]-1.
  - Net effect: channel i fires every div[i] frames, first fire div[i] frames after the write.
  - A channel with div=0 never fires.
  - Config write and frame_tick to the same channel in the same cycle: the config write wins and there is no fire.
- Overrun: an expiry on channel i while pending[i]=1 and pending[i] is not being cleared in that cycle sets overrun[i]. pending stays 1; requests do not queue.
- Expiry coinciding with the ack that clears pending[i]: pending[i] stays 1 and no overrun is flagged.
- FSM:
  - IDLE:
    - If any pending bit is set, select the first pending channel at or after rr, wrapping modulo NUM_CH.
    - Latch it as sel.
    - Next cycle: ch_tick[sel]=1 for exactly one cycle, busy=1, state=WAIT_ACK.
    - Selection latency is 1 cycle from pending visible to ch_tick.
  - WAIT_ACK:
    - ch_ack[sel] is sampled every cycle, including the cycle ch_tick is high.
    - On ack: clear pending[sel], set rr <= (sel+1) mod NUM_CH, busy <= 0, return to IDLE.
    - Acks on other channels are ignored; no pending change.
    - Minimum dispatch spacing is 2 cycles.
- enb low freezes cnt[] and ignores frame_tick. The FSM keeps dispatching already-pending channels.
- At most one ch_tick bit is ever high.

Optional Feature:
Macro: ACK_TIMEOUT_EN
- Defined:
  - A counter clears on WAIT_ACK entry and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYC-1 with no ack: set sticky timeout, clear pending[sel], advance rr, return to IDLE.
  - timeout is cleared only by rst.
- Not defined: no counter is built, timeout is tied to 0, and WAIT_ACK waits indefinitely.

Test Plan:
- Reset, write div0=1, div1=2, ack asserted the same cycle as ch_tick, 4 frame_ticks -> ch_tick[0] on every frame, ch_tick[1] on frames 2 and 4.
- Channels 0..3 all pending at once, acks immediate -> dispatch order 0,1,2,3, each ch_tick 2 cycles apart. Then re-pend 0 and 2 with rr=0 -> order 0,2.
- div2=1, withhold ack across 2 frame_ticks -> overrun[2]=1, single ch_tick[2]. Ack -> pending clear, overrun stays 1 until a config write to channel 2.
- enb=0 for 3 frame_ticks with div0=2 -> no new pending. Re-enable -> the fire lands on the 2nd enabled frame.
- rst asserted while busy=1 -> next cycle all outputs 0, state IDLE, pending cleared.
- ACK_TIMEOUT_EN, TIMEOUT_CYC=8, no ack -> busy drops 8 cycles after ch_tick, timeout=1, next pending channel dispatched.
